// File: rtl/net_rx_if.sv
// Network receive bundle: inbound data+tag words, ACK/NACK response toward the
// initiator, and the dequeue handshake toward the local consumer.
interface net_rx_if #(
   parameter int data_size  = 32,
   parameter int tag_size   = 8,
   parameter int fifo_depth = 4
);
   logic                              net_valid_in;
   logic [data_size+tag_size-1:0]     net_word_in;
   logic                              ack_valid_out;
   logic                              ack_nack_out;
   logic [tag_size-1:0]               ack_tag_out;
   logic                              deq_valid_out;
   logic [data_size-1:0]              deq_data_out;
   logic                              deq_ready_in;
   logic [$clog2(fifo_depth):0]       fifo_count_out;
   logic [7:0]                        err_count_out;

   modport master (
      output net_valid_in, net_word_in, deq_ready_in,
      input  ack_valid_out, ack_nack_out, ack_tag_out,
      input  deq_valid_out, deq_data_out, fifo_count_out, err_count_out
   );

   modport slave (
      input  net_valid_in, net_word_in, deq_ready_in,
      output ack_valid_out, ack_nack_out, ack_tag_out,
      output deq_valid_out, deq_data_out, fifo_count_out, err_count_out
   );
endinterface

// File: rtl/net_rx_responder.sv
// Network-side receiver: two-stage capture/classify pipeline that checks parity
// and sequence, answers ACK/NACK, and buffers accepted payloads in a FIFO.
module net_rx_responder #(
   parameter int data_size  = 32,
   parameter int tag_size   = 8,
   parameter int fifo_depth = 4
) (
   input logic     clk,
   input logic     reset,
   net_rx_if.slave bus
);
   localparam int word_w = data_size + tag_size;
   localparam int seq_w  = tag_size - 1;
   localparam int ptr_w  = $clog2(fifo_depth);
   localparam int cnt_w  = ptr_w + 1;

   function automatic logic parity_ok(input logic [data_size-1:0] d, input logic p);
      return ~(^{d, p});
   endfunction

   logic                 cap_valid_q, cap_valid_d;
   logic [word_w-1:0]    cap_word_q,  cap_word_d;
   logic                 ack_valid_q, ack_valid_d;
   logic                 ack_nack_q,  ack_nack_d;
   logic [tag_size-1:0]  ack_tag_q,   ack_tag_d;
   logic [seq_w-1:0]     exp_seq_q,   exp_seq_d;
   logic [7:0]           err_cnt_q,   err_cnt_d;
   logic [ptr_w-1:0]     wr_ptr_q,    wr_ptr_d;
   logic [ptr_w-1:0]     rd_ptr_q,    rd_ptr_d;
   logic [cnt_w-1:0]     count_q,     count_d;
   logic [data_size-1:0] mem_q [fifo_depth];
   logic [data_size-1:0] mem_d [fifo_depth];

   logic [data_size-1:0] cap_data_s;
   logic [tag_size-1:0]  cap_tag_s;
   logic [seq_w-1:0]     cap_seq_s;
   logic                 full_s;
   logic                 enq_s;
   logic                 deq_s;

   assign cap_data_s = cap_word_q[word_w-1:tag_size];
   assign cap_tag_s  = cap_word_q[tag_size-1:0];
   assign cap_seq_s  = cap_tag_s[seq_w-1:0];
   assign full_s     = (count_q == cnt_w'(fifo_depth));
   assign deq_s      = (count_q != {cnt_w{1'b0}}) && bus.deq_ready_in;

   always_comb begin
      cap_valid_d = bus.net_valid_in;
      cap_word_d  = bus.net_word_in;
   end

   // Classification priority: parity, in-order accept/stall, duplicate, out-of-order.
   always_comb begin
      ack_valid_d = 1'b0;
      ack_nack_d  = 1'b0;
      ack_tag_d   = {tag_size{1'b0}};
      enq_s       = 1'b0;
      exp_seq_d   = exp_seq_q;
      err_cnt_d   = err_cnt_q;
      if (cap_valid_q) begin
         if (!parity_ok(cap_data_s, cap_tag_s[tag_size-1])) begin
            ack_valid_d = 1'b1;
            ack_nack_d  = 1'b1;
            ack_tag_d   = {1'b0, exp_seq_q};
            if (err_cnt_q != 8'hFF) begin
               err_cnt_d = err_cnt_q + 8'd1;
            end else begin
               err_cnt_d = err_cnt_q;
            end
         end else if (cap_seq_s == exp_seq_q) begin
            if (!full_s) begin
               ack_valid_d = 1'b1;
               ack_tag_d   = cap_tag_s;
               enq_s       = 1'b1;
               exp_seq_d   = exp_seq_q + seq_w'(1'b1);
            end else begin
               ack_valid_d = 1'b0;
            end
         end else if (cap_seq_s == exp_seq_q - seq_w'(1'b1)) begin
            ack_valid_d = 1'b1;
            ack_tag_d   = cap_tag_s;
         end else begin
            ack_valid_d = 1'b1;
            ack_nack_d  = 1'b1;
            ack_tag_d   = {1'b0, exp_seq_q};
         end
      end else begin
         ack_valid_d = 1'b0;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (enq_s) begin
         mem_d[wr_ptr_q] = cap_data_s;
         wr_ptr_d        = wr_ptr_q + ptr_w'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
         rd_ptr_d = rd_ptr_q + ptr_w'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
         2'b10:   count_d = count_q + cnt_w'(1'b1);
         2'b01:   count_d = count_q - cnt_w'(1'b1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cap_valid_q <= 1'b0;
         cap_word_q  <= {word_w{1'b0}};
         ack_valid_q <= 1'b0;
         ack_nack_q  <= 1'b0;
         ack_tag_q   <= {tag_size{1'b0}};
         exp_seq_q   <= {seq_w{1'b0}};
         err_cnt_q   <= 8'd0;
         wr_ptr_q    <= {ptr_w{1'b0}};
         rd_ptr_q    <= {ptr_w{1'b0}};
         count_q     <= {cnt_w{1'b0}};
         mem_q       <= '{default: '0};
      end else begin
         cap_valid_q <= cap_valid_d;
         cap_word_q  <= cap_word_d;
         ack_valid_q <= ack_valid_d;
         ack_nack_q  <= ack_nack_d;
         ack_tag_q   <= ack_tag_d;
         exp_seq_q   <= exp_seq_d;
         err_cnt_q   <= err_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mem_q       <= mem_d;
      end
   end

   assign bus.ack_valid_out  = ack_valid_q;
   assign bus.ack_nack_out   = ack_nack_q;
   assign bus.ack_tag_out    = ack_tag_q;
   assign bus.deq_valid_out  = (count_q != {cnt_w{1'b0}});
   assign bus.deq_data_out   = mem_q[rd_ptr_q];
   assign bus.fifo_count_out = count_q;
   assign bus.err_count_out  = err_cnt_q;
endmodule

// File: tb/tb_net_rx_responder.sv
// Directed bench for net_rx_responder: vector table for single-word transactions,
// hand sequences for back-to-back traffic, FIFO stalls, sequence wrap and reset.
module tb_net_rx_responder;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   ack_seen;

   net_rx_if #(.data_size(32), .tag_size(8), .fifo_depth(4)) bus ();

   net_rx_responder #(.data_size(32), .tag_size(8), .fifo_depth(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  tag;
      logic        ack_v;
      logic        ack_n;
      logic [7:0]  ack_tag;
      logic [2:0]  cnt;
      logic [7:0]  err;
      logic [31:0] head;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] data, input logic [7:0] tag);
      bus.net_valid_in = 1'b1;
      bus.net_word_in  = {data, tag};
      tick();
      bus.net_valid_in = 1'b0;
      bus.net_word_in  = 40'd0;
      tick();
   endtask

   task automatic chk_ack(input string name, input logic v, input logic n, input logic [7:0] t);
      chk({name, ".valid"}, 64'(bus.ack_valid_out), 64'(v));
      chk({name, ".nack"},  64'(bus.ack_nack_out),  64'(n));
      chk({name, ".tag"},   64'(bus.ack_tag_out),   64'(t));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.net_valid_in = 1'b0;
      bus.net_word_in  = 40'd0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.deq_ready_in = 1'b0;
      //            data          tag    ack_v ack_n ack_tag cnt   err    head
      vecs[0] = '{32'h0000_0003, 8'h00, 1'b1, 1'b0, 8'h00, 3'd1, 8'd0, 32'h3};
      vecs[1] = '{32'h0000_0001, 8'h01, 1'b1, 1'b1, 8'h01, 3'd1, 8'd1, 32'h3};
      vecs[2] = '{32'h0000_0001, 8'h81, 1'b1, 1'b0, 8'h81, 3'd2, 8'd1, 32'h3};
      vecs[3] = '{32'h0000_0010, 8'h81, 1'b1, 1'b0, 8'h81, 3'd2, 8'd1, 32'h3};
      vecs[4] = '{32'h0000_0000, 8'h09, 1'b1, 1'b1, 8'h02, 3'd2, 8'd1, 32'h3};
      vecs[5] = '{32'h0000_0007, 8'h82, 1'b1, 1'b0, 8'h82, 3'd3, 8'd1, 32'h3};
      vecs[6] = '{32'hFFFF_FFFF, 8'h03, 1'b1, 1'b0, 8'h03, 3'd4, 8'd1, 32'h3};
      vecs[7] = '{32'h0000_0000, 8'h04, 1'b0, 1'b0, 8'h00, 3'd4, 8'd1, 32'h3};
      vecs[8] = '{32'h0000_0003, 8'h84, 1'b1, 1'b1, 8'h04, 3'd4, 8'd2, 32'h3};

      do_reset();
      chk("rst.ack_valid", 64'(bus.ack_valid_out), 64'd0);
      chk("rst.count",     64'(bus.fifo_count_out), 64'd0);
      chk("rst.deq_valid", 64'(bus.deq_valid_out), 64'd0);
      chk("rst.err",       64'(bus.err_count_out), 64'd0);

      for (int i = 0; i < 9; i++) begin
         send(vecs[i].data, vecs[i].tag);
         chk_ack($sformatf("vec%0d", i), vecs[i].ack_v, vecs[i].ack_n, vecs[i].ack_tag);
         chk($sformatf("vec%0d.count", i), 64'(bus.fifo_count_out), 64'(vecs[i].cnt));
         chk($sformatf("vec%0d.err", i),   64'(bus.err_count_out),  64'(vecs[i].err));
         chk($sformatf("vec%0d.head", i),  64'(bus.deq_data_out),   64'(vecs[i].head));
      end
      tick();
      chk("pulse_width", 64'(bus.ack_valid_out), 64'd0);

      // Back-to-back seq 0..4 with the consumer stalled.
      do_reset();
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (cyc < 5) begin
            bus.net_valid_in = 1'b1;
            bus.net_word_in  = {32'(cyc * 3), 8'(cyc)};
         end else begin
            bus.net_valid_in = 1'b0;
            bus.net_word_in  = 40'd0;
         end
         tick();
         if (cyc >= 1) begin
            if (cyc - 1 < 4) chk_ack($sformatf("b2b%0d", cyc - 1), 1'b1, 1'b0, 8'(cyc - 1));
            else             chk_ack("b2b4_full", 1'b0, 1'b0, 8'h00);
         end
      end
      chk("b2b.count", 64'(bus.fifo_count_out), 64'd4);
      chk("b2b.head",  64'(bus.deq_data_out),   64'd0);
      bus.deq_ready_in = 1'b1;
      tick();
      bus.deq_ready_in = 1'b0;
      chk("deq1.count", 64'(bus.fifo_count_out), 64'd3);
      chk("deq1.head",  64'(bus.deq_data_out),   64'd3);
      send(32'd0, 8'h04);
      chk_ack("retry4", 1'b1, 1'b0, 8'h04);
      chk("retry4.count", 64'(bus.fifo_count_out), 64'd4);
      bus.deq_ready_in = 1'b1;
      tick();
      tick();
      bus.deq_ready_in = 1'b0;
      chk("deq2.count", 64'(bus.fifo_count_out), 64'd2);
      chk("deq2.head",  64'(bus.deq_data_out),   64'd9);
      send(32'd0, 8'h05);
      chk_ack("seq5", 1'b1, 1'b0, 8'h05);
      chk("seq5.count", 64'(bus.fifo_count_out), 64'd3);
      send(32'd0, 8'h05);
      chk_ack("dup5", 1'b1, 1'b0, 8'h05);
      chk("dup5.count", 64'(bus.fifo_count_out), 64'd3);
      send(32'd0, 8'h09);
      chk_ack("seq9", 1'b1, 1'b1, 8'h06);
      chk("seq9.err", 64'(bus.err_count_out), 64'd0);

      // Advance expected_seq to 127 with the consumer draining, then wrap.
      do_reset();
      bus.deq_ready_in = 1'b1;
      ack_seen = 0;
      for (int s = 0; s < 129; s++) begin
         bus.net_valid_in = (s < 127);
         bus.net_word_in  = (s < 127) ? {32'd0, 8'(s)} : 40'd0;
         tick();
         if (bus.ack_valid_out && !bus.ack_nack_out) ack_seen++;
      end
      bus.net_valid_in = 1'b0;
      chk("burst.acks", 64'(ack_seen), 64'd127);
      send(32'd0, 8'h7F);
      chk_ack("seq127", 1'b1, 1'b0, 8'h7F);
      send(32'd0, 8'h00);
      chk_ack("wrap0", 1'b1, 1'b0, 8'h00);
      send(32'd0, 8'h02);
      chk_ack("after_wrap", 1'b1, 1'b1, 8'h01);

      // Reset the cycle after a word is sampled: no response, state cleared.
      bus.deq_ready_in = 1'b0;
      send(32'd0, 8'h01);
      chk("pre_rst.count", 64'(bus.fifo_count_out), 64'd1);
      send(32'd1, 8'h02);
      chk("pre_rst.err", 64'(bus.err_count_out), 64'd1);
      bus.net_valid_in = 1'b1;
      bus.net_word_in  = {32'd0, 8'h02};
      tick();
      bus.net_valid_in = 1'b0;
      bus.net_word_in  = 40'd0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst.ack",   64'(bus.ack_valid_out),  64'd0);
      tick();
      chk("midrst.ack2",  64'(bus.ack_valid_out),  64'd0);
      chk("midrst.count", 64'(bus.fifo_count_out), 64'd0);
      chk("midrst.dv",    64'(bus.deq_valid_out),  64'd0);
      chk("midrst.err",   64'(bus.err_count_out),  64'd0);
      send(32'd3, 8'h00);
      chk_ack("post_rst", 1'b1, 1'b0, 8'h00);
      chk("post_rst.count", 64'(bus.fifo_count_out), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
